// File: rtl/pixel_pkg.sv
// Shared types and address helper for the pixel fetch block.
package pixel_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        DRAIN,
        OUT
    } state_t;

    // 32-bit arithmetic; callers truncate to their address width for modulo wrap.
    function automatic logic [31:0] calc_byte_addr(
        input logic [31:0] base,
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] img_w,
        input logic [31:0] bpp
    );
        return base + (y * img_w + x) * bpp;
    endfunction

endpackage

// File: rtl/pixel_addr_calc.sv
// Latches a request's coordinates and base, then bounds-checks (or clamps when
// PIXEL_FETCH_CLAMP_EN is defined) and forms the first byte address of the pixel.
module pixel_addr_calc
    import pixel_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int IMG_W  = 900,
    parameter int IMG_H  = 300,
    parameter int BPP    = 3,
    parameter int X_W    = $clog2(IMG_W),
    parameter int Y_W    = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [ADDR_W-1:0] base,
    output logic              in_bounds,
    output logic [ADDR_W-1:0] addr
);

    logic [X_W-1:0]    x_reg;
    logic [Y_W-1:0]    y_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [X_W-1:0]    x_eff;
    logic [Y_W-1:0]    y_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg    <= '0;
            y_reg    <= '0;
            base_reg <= '0;
        end else if (load) begin
            x_reg    <= x;
            y_reg    <= y;
            base_reg <= base;
        end
    end

    // Compare in 32 bits so a power-of-two dimension does not alias to zero.
    always_comb begin
        x_eff = x_reg;
        y_eff = y_reg;
`ifdef PIXEL_FETCH_CLAMP_EN
        in_bounds = 1'b1;
        if (32'(x_reg) >= 32'(IMG_W)) x_eff = X_W'(IMG_W - 1);
        if (32'(y_reg) >= 32'(IMG_H)) y_eff = Y_W'(IMG_H - 1);
`else
        in_bounds = (32'(x_reg) < 32'(IMG_W)) && (32'(y_reg) < 32'(IMG_H));
`endif
        addr = ADDR_W'(calc_byte_addr(32'(base_reg), 32'(x_eff), 32'(y_eff),
                                      32'(IMG_W), 32'(BPP)));
    end

endmodule

// File: rtl/pixel_fetch.sv
// Fetches one BPP-byte pixel at (x, y) from a byte-wide memory with one-cycle read latency.
// Define PIXEL_FETCH_CLAMP_EN to clamp out-of-range coordinates instead of flagging pix_err.
module pixel_fetch
    import pixel_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int IMG_W  = 900,
    parameter int IMG_H  = 300,
    parameter int BPP    = 3,
    parameter int X_W    = $clog2(IMG_W),
    parameter int Y_W    = $clog2(IMG_H)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [X_W-1:0]        req_x,
    input  logic [Y_W-1:0]        req_y,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [BYTE_W-1:0]     mem_rd_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [BYTE_W*BPP-1:0] pix_data,
    output logic                  pix_err
);

    if (BPP < 1 || BPP > 4) begin : g_bpp_chk
        $error("pixel_fetch: BPP must be within 1..4");
    end
    if (ADDR_W > 32) begin : g_aw_chk
        $error("pixel_fetch: ADDR_W must not exceed 32");
    end
    if (longint'(IMG_W) * longint'(IMG_H) * longint'(BPP) > (longint'(1) << ADDR_W)) begin : g_size_chk
        $error("pixel_fetch: image does not fit in the address space");
    end

    state_t              state_reg, state_next;
    logic                accept;
    logic                in_bounds;
    logic [ADDR_W-1:0]   calc_addr;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [1:0]          rd_cnt_reg;
    logic [1:0]          cap_idx_reg;
    logic                rd_pend_reg;
    logic [BYTE_W-1:0]   lane_reg [BPP];

    assign accept   = req_valid && (state_reg == IDLE);
    assign mem_addr = mem_addr_reg;

    pixel_addr_calc #(
        .ADDR_W (ADDR_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .BPP    (BPP),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_addr_calc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .x         (req_x),
        .y         (req_y),
        .base      (base_addr),
        .in_bounds (in_bounds),
        .addr      (calc_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        pix_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ADDR;
            end
            ADDR:  state_next = in_bounds ? READ : OUT;
            READ: begin
                mem_rd_en = 1'b1;
                if (rd_cnt_reg == 2'(BPP - 1)) state_next = DRAIN;
            end
            DRAIN: state_next = OUT;
            OUT: begin
                pix_valid = 1'b1;
                if (pix_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // rd_pend_reg marks the cycle in which mem_rd_data carries a requested byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_reg <= '0;
            rd_cnt_reg   <= '0;
            cap_idx_reg  <= '0;
            rd_pend_reg  <= 1'b0;
        end else begin
            rd_pend_reg <= mem_rd_en;
            if (state_reg == ADDR) begin
                mem_addr_reg <= calc_addr;
                rd_cnt_reg   <= '0;
            end else if (state_reg == READ) begin
                mem_addr_reg <= mem_addr_reg + ADDR_W'(1);
                rd_cnt_reg   <= rd_cnt_reg + 2'd1;
            end
            if (accept)           cap_idx_reg <= '0;
            else if (rd_pend_reg) cap_idx_reg <= cap_idx_reg + 2'd1;
        end
    end

    for (genvar gi = 0; gi < BPP; gi++) begin : g_lane
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                     lane_reg[gi] <= '0;
            else if (accept)                                lane_reg[gi] <= '0;
            else if (rd_pend_reg && cap_idx_reg == 2'(gi))  lane_reg[gi] <= mem_rd_data;
        end
        assign pix_data[BYTE_W*gi +: BYTE_W] = lane_reg[gi];
    end

`ifdef PIXEL_FETCH_CLAMP_EN
    assign pix_err = 1'b0;
`else
    logic pix_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                pix_err_reg <= 1'b0;
        else if (accept)                           pix_err_reg <= 1'b0;
        else if (state_reg == ADDR && !in_bounds)  pix_err_reg <= 1'b1;
    end

    assign pix_err = pix_err_reg;
`endif

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: memory returns addr[7:0]; expected values are hand-computed.
module tb_pixel_fetch;

    localparam int ADDR_W = 20;
    localparam int BPP    = 3;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [X_W-1:0]      req_x = '0;
    logic [Y_W-1:0]      req_y = '0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_rd_data = 8'h00;
    logic                pix_valid;
    logic                pix_ready = 1'b0;
    logic [8*BPP-1:0]    pix_data;
    logic                pix_err;

    logic [ADDR_W-1:0]   rd_log [$];
    int                  illegal_rd = 0;
    int                  n_vec = 0;
    int                  n_bad = 0;

    pixel_fetch #(
        .ADDR_W (ADDR_W),
        .IMG_W  (900),
        .IMG_H  (300),
        .BPP    (BPP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .base_addr   (base_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_err     (pix_err)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle latency, data = low address byte; idle bus shows 0xEE.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_addr[7:0] : 8'hEE;
        if (rst_n && mem_rd_en) begin
            rd_log.push_back(mem_addr);
            if (req_ready || pix_valid) illegal_rd++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fetch(input string name, input int x, input int y, input int base,
                         input int exp_first, input int exp_reads, input int exp_data,
                         input int exp_err, input int exp_cyc, input int hold);
        int               cyc;
        logic [ADDR_W-1:0] a;
        logic [8*BPP-1:0] data0;
        rd_log.delete();
        req_x     = X_W'(x);
        req_y     = Y_W'(y);
        base_addr = ADDR_W'(base);
        req_valid = 1'b1;
        chk({name, ":req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!pix_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, ":valid_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({name, ":data"}, 32'(pix_data), 32'(exp_data));
        chk({name, ":err"}, 32'(pix_err), 32'(exp_err));
        chk({name, ":n_reads"}, 32'(rd_log.size()), 32'(exp_reads));
        for (int k = 0; k < exp_reads && k < rd_log.size(); k++) begin
            a = ADDR_W'(exp_first) + ADDR_W'(k);
            chk({name, ":rd_addr"}, 32'(rd_log[k]), 32'(a));
        end
        data0 = pix_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, ":hold_valid"}, 32'(pix_valid), 32'd1);
            chk({name, ":hold_data"}, 32'(pix_data), 32'(data0));
            chk({name, ":hold_ready"}, 32'(req_ready), 32'd0);
        end
        pix_ready = 1'b1;
        @(posedge clk); #1;
        pix_ready = 1'b0;
        chk({name, ":valid_drop"}, 32'(pix_valid), 32'd0);
        chk({name, ":ready_back"}, 32'(req_ready), 32'd1);
        $display("fetch %s x=%0d y=%0d base=0x%05h data=0x%06h err=%0d cycle=%0d reads=%0d",
                 name, x, y, base, data0, exp_err, cyc, exp_reads);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, ":req_ready"}, 32'(req_ready), 32'd1);
        chk({name, ":mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({name, ":mem_addr"}, 32'(mem_addr), 32'd0);
        chk({name, ":pix_valid"}, 32'(pix_valid), 32'd0);
        chk({name, ":pix_data"}, 32'(pix_data), 32'd0);
        chk({name, ":pix_err"}, 32'(pix_err), 32'd0);
    endtask

    initial begin
        #2;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        fetch("basic", 2, 1, 'h01000, 'h01A92, 3, 'h949392, 0, 6, 0);
        fetch("last", 899, 299, 0, 'hC5C0D, 3, 'h0F0E0D, 0, 6, 0);
`ifdef PIXEL_FETCH_CLAMP_EN
        fetch("oob_x", 900, 1, 'h01000, 'h02515, 3, 'h171615, 0, 6, 0);
        fetch("oob_y", 5, 300, 'h01000, 'hC6193, 3, 'h959493, 0, 6, 0);
`else
        fetch("oob_x", 900, 0, 'h01000, 0, 0, 0, 1, 2, 0);
        fetch("oob_y", 5, 300, 'h01000, 0, 0, 0, 1, 2, 0);
`endif
        fetch("wrap", 0, 0, 'hFFFFE, 'hFFFFE, 3, 'h00FFFE, 0, 6, 0);
        fetch("backpressure", 3, 0, 0, 'h00009, 3, 'h0B0A09, 0, 6, 5);

        // Reset while the third byte is being issued and the first is already captured.
        req_x = 10'd2; req_y = 9'd1; base_addr = 20'h01000; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_mid:pre_rd_en", 32'(mem_rd_en), 32'd1);
        chk("rst_mid:pre_data", 32'(pix_data), 32'h000092);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("rst_mid_release");
        fetch("after_rst", 2, 1, 'h01000, 'h01A92, 3, 'h949392, 0, 6, 0);

        chk("no_stray_rd", 32'(illegal_rd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
